// File: rtl/regfile_wb_merge_pkg.sv
// Core-wide write-back definitions: register/data widths and the write-request record.
package regfile_wb_merge_pkg;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    // One register-file write: destination index plus data.
    typedef struct packed {
        logic [REG_W-1:0]  wa;
        logic [DATA_W-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_merge_lq.sv
// wb_load_queue: small synchronous FIFO holding load write-backs that lost
// arbitration to the ALU. The head entry is visible combinationally so the
// arbiter can pick it in the same cycle.
module wb_load_queue
    import regfile_wb_merge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  wb_req_t                    push_data,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    // A push into a full queue is dropped; there is no push-through.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards the contents by emptying the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_merge.sv
// Write-back merge: arbitrates ALU results and returning load data onto the
// single register-file write port, and tracks outstanding loads per register.
module regfile_wb_merge
    import regfile_wb_merge_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                        CLK,
    input  logic                        nRESET,
    input  logic                        ALU_WEN,
    input  logic [REG_W-1:0]            ALU_WA,
    input  logic [DATA_W-1:0]           ALU_WD,
    input  logic                        LD_ISSUE,
    input  logic [REG_W-1:0]            LD_RD,
    input  logic                        LSU_VLD,
    input  logic [REG_W-1:0]            LSU_WA,
    input  logic [DATA_W-1:0]           LSU_WD,
    output logic                        LSU_RDY,
    output logic                        WEN_A,
    output logic [REG_W-1:0]            WA_A,
    output logic [DATA_W-1:0]           W_DA,
    output logic [NUM_REGS-1:0]         PEND,
    output logic [$clog2(LQ_DEPTH):0]   LQ_CNT
);

    localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

    logic                   wen_q, wen_d;
    logic [REG_W-1:0]       wa_q, wa_d;
    logic [DATA_W-1:0]      wd_q, wd_d;
    logic [NUM_REGS-1:0]    pend_q, pend_d;

    logic                   alu_req;
    logic                   lsu_xfer;
    wb_req_t                lsu_req;
    wb_req_t                q_head;
    logic [CNT_W-1:0]       q_count;
    logic                   q_full;
    logic                   q_empty;
    logic                   q_push;
    logic                   q_pop;

    logic                   ld_vld;
    wb_req_t                ld_req;
    logic                   ld_clash;
    logic                   ld_take;
    logic                   ld_write;

    assign alu_req  = ~ALU_WEN;
    assign LSU_RDY  = (q_count < CNT_W'(LQ_DEPTH));
    assign lsu_xfer = LSU_VLD & LSU_RDY;
    assign lsu_req  = '{wa: LSU_WA, wd: LSU_WD};

    wb_load_queue #(
        .DEPTH     (LQ_DEPTH)
    ) u_lq (
        .clk       (CLK),
        .rst_n     (nRESET),
        .push      (q_push),
        .push_data (lsu_req),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Load candidate is the queue head, or the live LSU transfer when the queue
    // is empty. It leaves when the ALU is idle (written) or when the ALU targets
    // the same register (discarded, the ALU value is newer).
    always_comb begin
        ld_vld   = ~q_empty | lsu_xfer;
        ld_req   = q_empty ? lsu_req : q_head;
        ld_clash = alu_req & ld_vld & (ld_req.wa == ALU_WA);
        ld_take  = ld_vld & (~alu_req | ld_clash);
        ld_write = ld_vld & ~alu_req;
        q_pop    = ~q_empty & ld_take;
        q_push   = lsu_xfer & ~(q_empty & ld_take);
    end

    // Output write selection: ALU first, then load; otherwise hold address/data.
    always_comb begin
        wen_d = 1'b1;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (alu_req) begin
            wen_d = 1'b0;
            wa_d  = ALU_WA;
            wd_d  = ALU_WD;
        end else if (ld_write) begin
            wen_d = 1'b0;
            wa_d  = ld_req.wa;
            wd_d  = ld_req.wd;
        end
    end

    // Pending-load scoreboard: a departing load clears, a new issue sets (set wins).
    always_comb begin
        pend_d = pend_q;
        if (ld_take)  pend_d[ld_req.wa] = 1'b0;
        if (LD_ISSUE) pend_d[LD_RD]     = 1'b1;
    end

    // Output register and scoreboard share one edge so PEND clears with the write.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wen_q  <= 1'b1;
            wa_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
        end else begin
            wen_q  <= wen_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    assign WEN_A  = wen_q;
    assign WA_A   = wa_q;
    assign W_DA   = wd_q;
    assign PEND   = pend_q;
    assign LQ_CNT = q_count;

    // Full flag is implied by the count compare above; kept for queue users.
    logic unused_full;
    assign unused_full = q_full;

endmodule

// File: tb/tb_regfile_wb_merge.sv
// Directed, table-driven bench for regfile_wb_merge (LQ_DEPTH=2).
module tb_regfile_wb_merge;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        ALU_WEN;
    logic [3:0]  ALU_WA;
    logic [31:0] ALU_WD;
    logic        LD_ISSUE;
    logic [3:0]  LD_RD;
    logic        LSU_VLD;
    logic [3:0]  LSU_WA;
    logic [31:0] LSU_WD;
    logic        LSU_RDY;
    logic        WEN_A;
    logic [3:0]  WA_A;
    logic [31:0] W_DA;
    logic [15:0] PEND;
    logic [1:0]  LQ_CNT;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_wb_merge #(.LQ_DEPTH(2)) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .ALU_WEN  (ALU_WEN),
        .ALU_WA   (ALU_WA),
        .ALU_WD   (ALU_WD),
        .LD_ISSUE (LD_ISSUE),
        .LD_RD    (LD_RD),
        .LSU_VLD  (LSU_VLD),
        .LSU_WA   (LSU_WA),
        .LSU_WD   (LSU_WD),
        .LSU_RDY  (LSU_RDY),
        .WEN_A    (WEN_A),
        .WA_A     (WA_A),
        .W_DA     (W_DA),
        .PEND     (PEND),
        .LQ_CNT   (LQ_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        alu_wen;
        logic [3:0]  alu_wa;
        logic [31:0] alu_wd;
        logic        ld_issue;
        logic [3:0]  ld_rd;
        logic        lsu_vld;
        logic [3:0]  lsu_wa;
        logic [31:0] lsu_wd;
        logic        e_wen;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;
        logic [15:0] e_pend;
        logic [1:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic aw, logic [3:0] awa, logic [31:0] awd,
                                logic li, logic [3:0] lrd,
                                logic lv, logic [3:0] lwa, logic [31:0] lwd,
                                logic ew, logic [3:0] ewa, logic [31:0] ewd,
                                logic [15:0] ep, logic [1:0] ec, logic er);
        vec_t v;
        v.alu_wen = aw;  v.alu_wa = awa; v.alu_wd = awd;
        v.ld_issue = li; v.ld_rd = lrd;
        v.lsu_vld = lv;  v.lsu_wa = lwa; v.lsu_wd = lwd;
        v.e_wen = ew;    v.e_wa = ewa;   v.e_wd = ewd;
        v.e_pend = ep;   v.e_cnt = ec;   v.e_rdy = er;
        return v;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic aw, logic [3:0] awa, logic [31:0] awd,
                         logic li, logic [3:0] lrd,
                         logic lv, logic [3:0] lwa, logic [31:0] lwd);
        ALU_WEN = aw;  ALU_WA = awa; ALU_WD = awd;
        LD_ISSUE = li; LD_RD = lrd;
        LSU_VLD = lv;  LSU_WA = lwa; LSU_WD = lwd;
    endtask

    task automatic idle();
        drive(1'b1, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(int idx, logic ew, logic [3:0] ewa, logic [31:0] ewd,
                               logic [15:0] ep, logic [1:0] ec, logic er);
        check("WEN_A",   idx, 32'(WEN_A),   32'(ew));
        check("WA_A",    idx, 32'(WA_A),    32'(ewa));
        check("W_DA",    idx, W_DA,         ewd);
        check("PEND",    idx, 32'(PEND),    32'(ep));
        check("LQ_CNT",  idx, 32'(LQ_CNT),  32'(ec));
        check("LSU_RDY", idx, 32'(LSU_RDY), 32'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ALU 3 write; idle; load R5 issued then bypassed 3 cycles later.
        vecs.push_back(mk(0,4'd3,32'h12345678, 0,0, 0,0,0,        0,4'd3,32'h12345678, 16'h0000,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd3,32'h12345678, 16'h0000,0,1));
        vecs.push_back(mk(1,0,0,               1,5, 0,0,0,        1,4'd3,32'h12345678, 16'h0020,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd3,32'h12345678, 16'h0020,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd3,32'h12345678, 16'h0020,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 1,5,32'hCAFEF00D, 0,4'd5,32'hCAFEF00D, 16'h0000,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd5,32'hCAFEF00D, 16'h0000,0,1));
        // Issue loads R1, R2, R7.
        vecs.push_back(mk(1,0,0,               1,1, 0,0,0,        1,4'd5,32'hCAFEF00D, 16'h0002,0,1));
        vecs.push_back(mk(1,0,0,               1,2, 0,0,0,        1,4'd5,32'hCAFEF00D, 16'h0006,0,1));
        vecs.push_back(mk(1,0,0,               1,7, 0,0,0,        1,4'd5,32'hCAFEF00D, 16'h0086,0,1));
        // Four ALU writes while the LSU offers R1, R2, R7; queue fills at 2.
        vecs.push_back(mk(0,4'd8,32'hA0,       0,0, 1,1,32'h11,   0,4'd8,32'hA0, 16'h0086,1,1));
        vecs.push_back(mk(0,4'd9,32'hA1,       0,0, 1,2,32'h22,   0,4'd9,32'hA1, 16'h0086,2,0));
        vecs.push_back(mk(0,4'd10,32'hA2,      0,0, 1,7,32'h77,   0,4'd10,32'hA2, 16'h0086,2,0));
        vecs.push_back(mk(0,4'd11,32'hA3,      0,0, 1,7,32'h77,   0,4'd11,32'hA3, 16'h0086,2,0));
        vecs.push_back(mk(1,0,0,               0,0, 1,7,32'h77,   0,4'd1,32'h11, 16'h0084,1,1));
        vecs.push_back(mk(1,0,0,               0,0, 1,7,32'h77,   0,4'd2,32'h22, 16'h0080,1,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        0,4'd7,32'h77, 16'h0000,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd7,32'h77, 16'h0000,0,1));
        // Queue a load to R6, then ALU writes R6 while it is the head.
        vecs.push_back(mk(1,0,0,               1,6, 0,0,0,        1,4'd7,32'h77, 16'h0040,0,1));
        vecs.push_back(mk(0,4'd12,32'hB0,      0,0, 1,6,32'h66,   0,4'd12,32'hB0, 16'h0040,1,1));
        vecs.push_back(mk(0,4'd6,32'hB1,       0,0, 0,0,0,        0,4'd6,32'hB1, 16'h0000,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd6,32'hB1, 16'h0000,0,1));
        // Re-issue of R4 in the cycle the older R4 load is written: PEND stays set.
        vecs.push_back(mk(1,0,0,               1,4, 0,0,0,        1,4'd6,32'hB1, 16'h0010,0,1));
        vecs.push_back(mk(1,0,0,               1,4, 1,4,32'h44,   0,4'd4,32'h44, 16'h0010,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd4,32'h44, 16'h0010,0,1));
        // Bypass-path contention: ALU R4 and LSU R4 together; load discarded.
        vecs.push_back(mk(0,4'd4,32'hC0,       0,0, 1,4,32'h45,   0,4'd4,32'hC0, 16'h0000,0,1));
        vecs.push_back(mk(1,0,0,               0,0, 0,0,0,        1,4'd4,32'hC0, 16'h0000,0,1));

        idle();
        nRESET = 1'b0;
        #12;
        check_state(-1, 1'b1, 4'd0, 32'd0, 16'h0000, 2'd0, 1'b1);
        @(negedge CLK);
        nRESET = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].alu_wen, vecs[i].alu_wa, vecs[i].alu_wd,
                  vecs[i].ld_issue, vecs[i].ld_rd,
                  vecs[i].lsu_vld, vecs[i].lsu_wa, vecs[i].lsu_wd);
            step();
            $display("step %0d: WEN_A=%b WA_A=%0d W_DA=%h PEND=%h LQ_CNT=%0d LSU_RDY=%b",
                     i, WEN_A, WA_A, W_DA, PEND, LQ_CNT, LSU_RDY);
            check_state(i, vecs[i].e_wen, vecs[i].e_wa, vecs[i].e_wd,
                        vecs[i].e_pend, vecs[i].e_cnt, vecs[i].e_rdy);
        end

        // Reset mid-operation with two queued loads and PEND=0x0090.
        drive(1, 0, 0, 1, 4'd4, 0, 0, 0); step();
        drive(1, 0, 0, 1, 4'd7, 0, 0, 0); step();
        drive(0, 4'd1, 32'hD1, 0, 0, 1, 4'd4, 32'h44); step();
        drive(0, 4'd2, 32'hD2, 0, 0, 1, 4'd7, 32'h77); step();
        $display("pre-reset: WEN_A=%b WA_A=%0d PEND=%h LQ_CNT=%0d", WEN_A, WA_A, PEND, LQ_CNT);
        check_state(100, 1'b0, 4'd2, 32'hD2, 16'h0090, 2'd2, 1'b0);
        idle();
        #2;
        nRESET = 1'b0;
        #1;
        $display("in reset: WEN_A=%b PEND=%h LQ_CNT=%0d", WEN_A, PEND, LQ_CNT);
        check_state(101, 1'b1, 4'd0, 32'd0, 16'h0000, 2'd0, 1'b1);
        step();
        check_state(102, 1'b1, 4'd0, 32'd0, 16'h0000, 2'd0, 1'b1);
        @(negedge CLK);
        nRESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            $display("post-reset %0d: WEN_A=%b WA_A=%0d LQ_CNT=%0d", k, WEN_A, WA_A, LQ_CNT);
            check_state(103 + k, 1'b1, 4'd0, 32'd0, 16'h0000, 2'd0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_merge.md
# regfile_wb_merge

Write-back merge stage that sits directly upstream of the 16x32 general register file and drives its single write port (WEN_A/WA_A/W_DA). It arbitrates between the ALU result path, which is never stalled, and the load-data return path from the LSU, which is buffered in a small queue. It also maintains a pending-load scoreboard that the issue stage uses to stall on RAW and WAW hazards against outstanding loads.

## Interface
- LQ_DEPTH, 2, load-queue entries; power of two, ≥2
- CLK  in  1  single clock, rising edge
- nRESET  in  1  asynchronous, active-low reset
- ALU_WEN  in  1  ALU write request, active-low
- ALU_WA  in  4  ALU destination register
- ALU_WD  in  32  ALU result
- LD_ISSUE  in  1  a load is issued this cycle, active-high
- LD_RD  in  4  destination register of the issued load
- LSU_VLD  in  1  load data valid
- LSU_WA  in  4  load destination register
- LSU_WD  in  32  load data
- LSU_RDY  out  1  queue can accept; transfer occurs when LSU_VLD & LSU_RDY
- WEN_A  out  1  register-file write enable, active-low, registered
- WA_A  out  4  register-file write address, registered
- W_DA  out  32  register-file write data, registered
- PEND  out  16  bit n set = load to Rn outstanding
- LQ_CNT  out  log2(LQ_DEPTH)+1  queue occupancy

## Operation
- Each cycle, at most one write is selected for the output register, in priority order: ALU (ALU_WEN=0), then queue head, then an LSU bypass.
- The LSU bypass applies only when the queue is empty, no ALU write is requested, and an LSU transfer occurs. The data goes straight to the output and is not enqueued.
- An LSU transfer that is not bypassed is pushed at the queue tail. The queue head pops only when selected.
- LSU_RDY = (LQ_CNT < LQ_DEPTH). It is combinational from the count only and never depends on LSU_VLD. There is no push-through when full.
- Push and pop in the same cycle are legal whenever the queue is not full; the count is unchanged.
- Contention: if the ALU write and the selected load target the same register in the same cycle, the ALU write wins and that load is discarded (popped or bypass-consumed without writing). Its PEND bit is still cleared.
- Scoreboard:
  - LD_ISSUE sets PEND[LD_RD].
  - A load write leaving for the output register clears PEND[WA].
  - If a set and a clear hit the same bit in one cycle, set wins.
- Issue must not dispatch an instruction whose source or destination has its PEND bit set; this block does not check that.
- Pointers wrap modulo LQ_DEPTH. The count saturates by construction.

## Timing
- Latency: a request accepted in cycle N appears on WEN_A/WA_A/W_DA in cycle N+1. The register file writes on the N+1 edge. There is exactly one output cycle per write.
- A queued entry waits one extra cycle for every cycle in which an ALU write is present.
- With no request selected, the next-cycle WEN_A=1. WA_A and W_DA hold their last values.
- PEND updates on the same edge that loads the output register, so a bit clears in the same cycle that WEN_A=0 is presented for that load.
- Reset values: WEN_A=1, WA_A=0, W_DA=0, PEND=0, LQ_CNT=0, LSU_RDY=1.
- Reset mid-operation: queue contents and pending bits are discarded immediately, and the output write is cancelled (WEN_A=1) asynchronously.

## Structure
- Shared package (core-wide):
  - register-index width (4) and data width (32) constants;
  - the typedef for a write request {wa[3:0], wd[31:0]}.
- One sub-module is natural: wb_load_queue, a parameterised synchronous FIFO with count, full and empty outputs.
- The top level holds the arbiter, the output register and the scoreboard.

## Test plan
- Reset, then a single ALU write with ALU_WA=3, ALU_WD=0x12345678 -> next cycle WEN_A=0, WA_A=3, W_DA=0x12345678; the following cycle WEN_A=1.
- LD_ISSUE with LD_RD=5, then 3 cycles later LSU_VLD with WA=5, WD=0xCAFEF00D while idle -> PEND[5]=1 until bypass write; WEN_A=0, WA_A=5 one cycle after the transfer; PEND[5]=0 that same cycle; LQ_CNT stays 0.
- ALU writes on 4 consecutive cycles while the LSU offers 3 loads (R1, R2, R7) -> LSU_RDY drops after 2 are accepted; after the ALU burst, outputs show R1, R2, R7 in order on consecutive cycles.
- ALU_WA=6 and a queue head targeting 6 in the same cycle -> W_DA equals the ALU data; the load is discarded; PEND[6]=0; LQ_CNT decrements.
- LD_ISSUE for R4 in the same cycle that an older R4 load is written -> PEND[4] remains 1.
- Assert nRESET low with 2 entries queued and PEND=0x0090 -> WEN_A=1, PEND=0, LQ_CNT=0 immediately; after release, no stale write appears.
